universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

A parametrised universal shift register with a registered parallel output. One command per cycle selects hold, parallel load, logical or arithmetic shift, single-step rotate, or a multi-cycle burst rotate. The burst rotate uses a busy/done handshake. The block is the general-purpose shift/rotate datapath element for lab designs, and it supersedes fixed-width, rotate-only PIPO registers.

## Interface
- WIDTH, 8, register width in bits (must be 2 or more)
- STEP_W, 8, width of the burst step count
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  command valid this cycle
- op  input  3  command code; see Operation
- data_in  input  WIDTH  parallel load value
- ser_in  input  1  serial fill bit for SHR and SHL
- amt  input  STEP_W  burst rotate step count, sampled on accept
- data_out  output  WIDTH  register contents, registered
- ser_out  output  1  last bit shifted or rotated out, registered
- busy  output  1  burst rotation in progress
- done  output  1  one-cycle pulse when a burst completes

## Operation
- Reset (rst=1 at an edge) clears every output to 0 (data_out, ser_out, busy, done) and puts the FSM in IDLE. Reset overrides everything, including an active burst.
- A command is accepted at an edge when en=1 and busy=0. With en=0 or busy=1, data_out holds and en/op are ignored.
- Command codes:
  - 0 HOLD: no change.
  - 1 LOAD: data_out<=data_in.
  - 2 SHR: {ser_in, d[W-1:1]}.
  - 3 SHL: {d[W-2:0], ser_in}.
  - 4 ROR: {d[0], d[W-1:1]}.
  - 5 ROL: {d[W-2:0], d[W-1]}.
  - 6 ASR: {d[W-1], d[W-1:1]}.
  - 7 BURST: rotate right amt times, one step per cycle.
- ser_out rules:
  - SHR, ROR, ASR and each burst step: ser_out<=old d[0].
  - SHL, ROL: ser_out<=old d[W-1].
  - HOLD, LOAD: ser_out unchanged.
- done defaults to 0 every cycle unless it is set as described below.
- FSM states are IDLE and RUN, with a STEP_W remaining-count register.
  - IDLE with BURST accepted and amt>0: load remaining<=amt, set busy<=1, go to RUN. data_out does not change on the accept edge.
  - IDLE with BURST accepted and amt=0: done<=1, data unchanged, stay in IDLE. busy never asserts.
  - RUN, each edge: rotate right by 1, update ser_out, remaining<=remaining-1.
  - RUN with remaining=1: also set busy<=0 and done<=1, and return to IDLE.
- The rotation count is exact for any amt up to 2^STEP_W-1. amt=WIDTH returns the original value. There is no modulo shortcut; the full amt cycles are spent.

## Timing
- Single-step commands take effect on the accept edge, so the result is visible on data_out in the next cycle (latency 1).
- BURST with amt=N>0:
  - busy is high for exactly N cycles, starting the cycle after the accept edge.
  - The final rotated value and done=1 appear together in the cycle after the Nth rotation edge.
  - A new command can be accepted in that same done cycle.
- BURST with amt=0: done pulses in the cycle after accept.
- Reset mid-burst: outputs are 0 and FSM is IDLE in the cycle after the reset edge. Any pending done is lost.

## Structure
- A shared package shift_pkg holds:
  - the op code localparams (OP_HOLD … OP_BURST);
  - the FSM state encoding (IDLE, RUN).
- One natural combinational sub-module, shift_core, computes {next_data, out_bit} from (op, data, ser_in). It is reused for burst steps with op forced to ROR.
- The top level contains the FSM, the remaining counter, and the output registers.

## Test plan
All scenarios use WIDTH=8.
1. Reset, then LOAD 8'hB5 -> data_out=B5 the next cycle; busy=0, done=0, ser_out=0.
2. Starting from B5:
   - ROR -> DA, ser_out=1.
   - Reload B5, then ROL -> 6B, ser_out=1.
3. Starting from 8'h9D:
   - SHR with ser_in=0 -> 4E, ser_out=1.
   - Reload, then ASR -> CE.
   - Reload, then SHL with ser_in=1 -> 3B, ser_out=1.
4. B5 with BURST amt=3:
   - busy is high for 3 cycles, passing through DA and 6D.
   - B6 appears with a single done pulse.
   - A LOAD 8'h00 issued while busy is ignored.
5. B5 with BURST amt=0 -> done the next cycle, busy stays 0, data_out=B5. Then BURST amt=8 -> B5 after 8 busy cycles.
6. B5 with BURST amt=5, and rst asserted during the 2nd busy cycle -> all outputs 0 the next cycle, no done pulse. A subsequent LOAD is accepted immediately.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: command codes and FSM states.
package shift_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_ROL   = 3'd5;
  localparam logic [2:0] OP_ASR   = 3'd6;
  localparam logic [2:0] OP_BURST = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational single-step shift/rotate datapath; BURST is treated as no change here.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_data,
  output logic             out_bit,
  output logic             out_bit_we
);

  always_comb begin
    next_data  = data;
    out_bit    = 1'b0;
    out_bit_we = 1'b0;
    case (op)
      OP_LOAD: next_data = load_data;
      OP_SHR: begin
        next_data  = {ser_in, data[WIDTH-1:1]};
        out_bit    = data[0];
        out_bit_we = 1'b1;
      end
      OP_SHL: begin
        next_data  = {data[WIDTH-2:0], ser_in};
        out_bit    = data[WIDTH-1];
        out_bit_we = 1'b1;
      end
      OP_ROR: begin
        next_data  = {data[0], data[WIDTH-1:1]};
        out_bit    = data[0];
        out_bit_we = 1'b1;
      end
      OP_ROL: begin
        next_data  = {data[WIDTH-2:0], data[WIDTH-1]};
        out_bit    = data[WIDTH-1];
        out_bit_we = 1'b1;
      end
      OP_ASR: begin
        next_data  = {data[WIDTH-1], data[WIDTH-1:1]};
        out_bit    = data[0];
        out_bit_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: single-cycle shift/rotate/load commands plus a
// multi-cycle burst rotate-right with busy/done handshake.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ser_in,
  input  logic [STEP_W-1:0] amt,
  output logic [WIDTH-1:0]  data_out,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              ser_q, ser_d;
  logic              done_q, done_d;

  logic [2:0]        core_op;
  logic [WIDTH-1:0]  core_data;
  logic              core_bit;
  logic              core_bit_we;

  // During a burst the core is reused as a plain rotate-right.
  assign core_op = (state_q == RUN) ? OP_ROR : op;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .op         (core_op),
    .data       (data_q),
    .load_data  (data_in),
    .ser_in     (ser_in),
    .next_data  (core_data),
    .out_bit    (core_bit),
    .out_bit_we (core_bit_we)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    ser_d       = ser_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (op == OP_BURST) begin
            if (amt == '0) begin
              done_d = 1'b1;
            end else begin
              remaining_d = amt;
              state_d     = RUN;
            end
          end else begin
            data_d = core_data;
            if (core_bit_we) ser_d = core_bit;
          end
        end
      end
      RUN: begin
        data_d      = core_data;
        ser_d       = core_bit;
        remaining_d = remaining_q - STEP_W'(1);
        if (remaining_q == STEP_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      ser_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      ser_q       <= ser_d;
      done_q      <= done_d;
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed plus randomized bench for universal_shift_register against a behavioural model.
module tb_universal_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] data_in = '0;
  logic         ser_in = 1'b0;
  logic [7:0]   amt = '0;
  logic [W-1:0] data_out;
  logic         ser_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model state: value, last bit out, burst steps still owed, done pulse.
  int m_data = 0;
  int m_ser  = 0;
  int m_left = 0;
  int m_done = 0;

  universal_shift_register #(.WIDTH(W), .STEP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .op       (op),
    .data_in  (data_in),
    .ser_in   (ser_in),
    .amt      (amt),
    .data_out (data_out),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rotr(input int v);
    return ((v >> 1) | ((v & 1) << (W - 1))) & 8'hFF;
  endfunction

  task automatic model_edge();
    int d;
    d = m_data;
    if (rst) begin
      m_data = 0; m_ser = 0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_ser  = d & 1;
        m_data = rotr(d);
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (en) begin
        case (op)
          3'd1: m_data = int'(data_in);
          3'd2: begin m_ser = d & 1; m_data = (d >> 1) | (int'(ser_in) << (W - 1)); end
          3'd3: begin m_ser = (d >> (W - 1)) & 1; m_data = ((d << 1) | int'(ser_in)) & 8'hFF; end
          3'd4: begin m_ser = d & 1; m_data = rotr(d); end
          3'd5: begin m_ser = (d >> (W - 1)) & 1; m_data = ((d << 1) | (d >> (W - 1))) & 8'hFF; end
          3'd6: begin m_ser = d & 1; m_data = (d >> 1) | (d & 8'h80); end
          3'd7: begin
            if (amt == 0) m_done = 1;
            else m_left = int'(amt);
          end
          default: ;
        endcase
      end
    end
  endtask

  // One clock: drive inputs, take the edge, then compare every output with the model.
  task automatic step(input logic r, input logic e, input logic [2:0] o,
                      input logic [W-1:0] d, input logic s, input logic [7:0] a);
    rst = r; en = e; op = o; data_in = d; ser_in = s; amt = a;
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t rst=%0b en=%0b op=%0d din=%h sin=%0b amt=%0d -> dout=%h ser=%0b busy=%0b done=%0b",
             $time, r, e, o, d, s, a, data_out, ser_out, busy, done);
    chk("model_data", int'(data_out), m_data);
    chk("model_ser", int'(ser_out), m_ser);
    chk("model_busy", int'(busy), (m_left > 0) ? 1 : 0);
    chk("model_done", int'(done), m_done);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'd0);
  endtask

  initial begin
    // 1: reset, then load
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'd0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    step(1'b0, 1'b1, 3'd1, 8'hB5, 1'b0, 8'd0);
    chk("load_b5", int'(data_out), 8'hB5);
    chk("load_ser", int'(ser_out), 0);
    chk("load_done", int'(done), 0);

    // 2: rotates
    step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 8'd0);
    chk("ror_data", int'(data_out), 8'hDA);
    chk("ror_ser", int'(ser_out), 1);
    step(1'b0, 1'b1, 3'd1, 8'hB5, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'd0);
    chk("rol_data", int'(data_out), 8'h6B);
    chk("rol_ser", int'(ser_out), 1);

    // 3: shifts from 9D
    step(1'b0, 1'b1, 3'd1, 8'h9D, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 8'd0);
    chk("shr_data", int'(data_out), 8'h4E);
    chk("shr_ser", int'(ser_out), 1);
    step(1'b0, 1'b1, 3'd1, 8'h9D, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'd0);
    chk("asr_data", int'(data_out), 8'hCE);
    step(1'b0, 1'b1, 3'd1, 8'h9D, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 8'd0);
    chk("shl_data", int'(data_out), 8'h3B);
    chk("shl_ser", int'(ser_out), 1);

    // 4: burst of 3 with an ignored load while busy
    step(1'b0, 1'b1, 3'd1, 8'hB5, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'd3);
    chk("b3_busy1", int'(busy), 1);
    chk("b3_hold", int'(data_out), 8'hB5);
    step(1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'd0);
    chk("b3_da", int'(data_out), 8'hDA);
    chk("b3_busy2", int'(busy), 1);
    idle();
    chk("b3_6d", int'(data_out), 8'h6D);
    idle();
    chk("b3_b6", int'(data_out), 8'hB6);
    chk("b3_done", int'(done), 1);
    chk("b3_notbusy", int'(busy), 0);
    idle();
    chk("b3_done_once", int'(done), 0);

    // 5: burst of 0, then burst of WIDTH
    step(1'b0, 1'b1, 3'd1, 8'hB5, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'd0);
    chk("b0_done", int'(done), 1);
    chk("b0_busy", int'(busy), 0);
    chk("b0_data", int'(data_out), 8'hB5);
    step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'd8);
    for (int i = 0; i < 7; i++) begin
      idle();
      chk("b8_busy", int'(busy), 1);
    end
    idle();
    chk("b8_data", int'(data_out), 8'hB5);
    chk("b8_done", int'(done), 1);

    // 6: reset during the second busy cycle
    step(1'b0, 1'b1, 3'd1, 8'hB5, 1'b0, 8'd0);
    step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'd5);
    idle();
    chk("b5_busy2", int'(busy), 1);
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'd0);
    chk("b5_rst_data", int'(data_out), 0);
    chk("b5_rst_busy", int'(busy), 0);
    chk("b5_rst_done", int'(done), 0);
    step(1'b0, 1'b1, 3'd1, 8'hA3, 1'b0, 8'd0);
    chk("b5_reload", int'(data_out), 8'hA3);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("b5_no_done", int'(done), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           8'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
